// File: rtl/reverse_key_schedule.sv
// ---------------------------------------------------------------------------
// reverse_key_schedule
//
// Walks the AES-128 key schedule backwards. Starting from the round-10 key
// it emits round keys 10, 9, ... 0, one per valid/ready handshake. Each step
// undoes one forward expansion round, so only the final round key has to be
// stored by whoever needs decryption keys.
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset, highest priority
//   i_start      begin a schedule (sampled only while idle)
//   i_last_key   round-10 key, word 0 in bits 127:96, captured on start
//   i_key_ready  consumer accepts the current key when high with o_key_valid
//   o_key_valid  o_round_key / o_round hold a valid round key
//   o_round_key  current round key, word 0 in bits 127:96
//   o_round      round index of o_round_key (10 down to 0)
//   o_busy       high whenever a schedule is in progress
//   o_done       one-cycle pulse after the round-0 key is accepted
// ---------------------------------------------------------------------------
module reverse_key_schedule (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [127:0] i_last_key,
    input  logic         i_key_ready,
    output logic         o_key_valid,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_round,
    output logic         o_busy,
    output logic         o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;

    logic         handshake;
    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rotP3, subP3;
    logic [7:0]   rcon;
    logic [127:0] prevKey;

    // Forward AES S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int idx;
        idx = 255 - int'(b);
        return SBOX[idx*8 +: 8];
    endfunction

    function automatic logic [7:0] rconOf(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    assign handshake = (state_q == EMIT) && i_key_ready;

    // Inverse expansion step. The xor chain is undone from the top word
    // down, so p3 is available first and feeds the g() function that
    // recovers p0.
    always_comb begin
        k0      = key_q[127:96];
        k1      = key_q[95:64];
        k2      = key_q[63:32];
        k3      = key_q[31:0];
        p3      = k3 ^ k2;
        p2      = k2 ^ k1;
        p1      = k1 ^ k0;
        rotP3   = {p3[23:0], p3[31:24]};
        subP3   = {sbox(rotP3[31:24]), sbox(rotP3[23:16]),
                   sbox(rotP3[15:8]),  sbox(rotP3[7:0])};
        rcon    = rconOf(round_q);
        p0      = k0 ^ subP3 ^ {rcon, 24'h0};
        prevKey = {p0, p1, p2, p3};
    end

    // State register. Reset clears the key and round so nothing of an
    // aborted schedule remains visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    // Next-state logic. Start is only looked at in IDLE, so DONE always
    // passes through one IDLE cycle before a new schedule can be accepted.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    key_d   = i_last_key;
                    round_d = 4'd10;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (handshake) begin
                    if (round_q == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        key_d   = prevKey;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are pure functions of the registered state.
    always_comb begin
        o_key_valid = (state_q == EMIT);
        o_busy      = (state_q != IDLE);
        o_done      = (state_q == DONE);
        o_round_key = key_q;
        o_round     = round_q;
    end

endmodule

// File: tb/tb_reverse_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_reverse_key_schedule
//
// Self-checking bench for reverse_key_schedule. A reference model expands
// cipher keys forward (S-box derived from GF(2^8) inversion plus the affine
// map) and tracks the expected handshake sequence; a compare process checks
// the DUT against it every cycle. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_reverse_key_schedule;

    typedef logic [10:0][127:0] sched_t;

    localparam int M_IDLE = 0;
    localparam int M_EMIT = 1;
    localparam int M_DONE = 2;

    localparam logic [127:0] FIPS_CIPHER = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9     = 128'hac7766f319fadc2128d12941575c006e;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [127:0] i_last_key;
    logic         i_key_ready;
    logic         o_key_valid;
    logic [127:0] o_round_key;
    logic [3:0]   o_round;
    logic         o_busy;
    logic         o_done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sboxTab [0:255];
    logic [127:0] tbCipher;

    sched_t mSched;
    int     mState = M_IDLE;
    int     mRound = 0;
    bit     mArmed = 1'b0;
    bit     mKnown = 1'b0;

    always #5 clk = ~clk;

    reverse_key_schedule dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_last_key  (i_last_key),
        .i_key_ready (i_key_ready),
        .o_key_valid (o_key_valid),
        .o_round_key (o_round_key),
        .o_round     (o_round),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sboxRef(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Forward AES-128 key expansion; element r is the round-r key.
    function automatic sched_t expandKey(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxTab[t[31:24]], sboxTab[t[23:16]],
                     sboxTab[t[15:8]], sboxTab[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs, cross the next rising edge, settle 2 ns.
    task automatic applyStimulus(input logic s, input logic [127:0] k,
                                 input logic rdy, input logic r);
        i_start     = s;
        i_last_key  = k;
        i_key_ready = rdy;
        rst         = r;
        @(posedge clk);
        #2;
    endtask

    // Handshake until o_done shows up, counting accepted keys.
    task automatic runToDone(input int maxCycles, input bit randomReady,
                             output int nKeys, output logic [127:0] lastKey);
        bit   seen;
        logic rdy;
        seen    = 1'b0;
        nKeys   = 0;
        lastKey = '0;
        for (int c = 0; c < maxCycles && !seen; c++) begin
            if (o_done) begin
                seen = 1'b1;
            end else begin
                rdy = randomReady ? logic'($urandom_range(3) != 0) : 1'b1;
                if (o_key_valid && rdy) begin
                    nKeys++;
                    if (o_round == 4'd0) lastKey = o_round_key;
                end
                applyStimulus(1'b0, i_last_key, rdy, 1'b0);
            end
        end
        checkOutput("done_within_budget", 128'(seen), 128'd1);
    endtask

    // Compare process: check outputs against the model's current state,
    // then advance the model with the inputs present before the next edge.
    always @(negedge clk) begin
        if (mArmed) begin
            checkOutput("key_valid", 128'(o_key_valid), 128'(mState == M_EMIT));
            checkOutput("busy",      128'(o_busy),      128'(mState != M_IDLE));
            checkOutput("done",      128'(o_done),      128'(mState == M_DONE));
            if (mState == M_EMIT) begin
                checkOutput("round",     128'(o_round), 128'(mRound));
                checkOutput("round_key", o_round_key,   mSched[mRound]);
            end else if (mKnown) begin
                checkOutput("round_after_reset", 128'(o_round), 128'd0);
                checkOutput("key_after_reset",   o_round_key,   128'd0);
            end
        end
        if (rst) begin
            mState = M_IDLE;
            mRound = 0;
            mArmed = 1'b1;
            mKnown = 1'b1;
        end else if (mArmed) begin
            case (mState)
                M_IDLE: if (i_start) begin
                    mSched = expandKey(tbCipher);
                    mRound = 10;
                    mState = M_EMIT;
                    mKnown = 1'b0;
                end
                M_EMIT: if (i_key_ready) begin
                    if (mRound == 0) mState = M_DONE;
                    else mRound = mRound - 1;
                end
                default: mState = M_IDLE;
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           nKeys;
        int           doneCount;
        int           doneAt [0:1];
        logic [127:0] lastKey;
        sched_t       s;
        logic [127:0] otherLast;

        for (int i = 0; i < 256; i++) sboxTab[i] = sboxRef(8'(i));
        tbCipher    = FIPS_CIPHER;
        i_start     = 1'b0;
        i_last_key  = '0;
        i_key_ready = 1'b0;
        rst         = 1'b1;

        // Pin the reference model to published values.
        checkOutput("model_sbox_00", 128'(sboxTab[8'h00]), 128'h63);
        checkOutput("model_sbox_53", 128'(sboxTab[8'h53]), 128'hed);
        s = expandKey(FIPS_CIPHER);
        checkOutput("model_fips_r10", s[10], FIPS_R10);
        checkOutput("model_fips_r9",  s[9],  FIPS_R9);

        // Reset state.
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("reset_valid", 128'(o_key_valid), 128'd0);
        checkOutput("reset_busy",  128'(o_busy),      128'd0);
        checkOutput("reset_done",  128'(o_done),      128'd0);
        checkOutput("reset_round", 128'(o_round),     128'd0);
        checkOutput("reset_key",   o_round_key,       128'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);

        // FIPS-197 vector with ready held high, cycle-exact.
        $display("[TB] FIPS-197 schedule");
        tbCipher = FIPS_CIPHER;
        applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b0);
        checkOutput("fips_t1_round", 128'(o_round), 128'd10);
        checkOutput("fips_t1_key",   o_round_key,   FIPS_R10);
        applyStimulus(1'b0, 128'hdeadbeef, 1'b1, 1'b0);
        checkOutput("fips_t2_round", 128'(o_round), 128'd9);
        checkOutput("fips_t2_key",   o_round_key,   FIPS_R9);
        for (int i = 0; i < 9; i++) applyStimulus(1'b0, 128'hdeadbeef, 1'b1, 1'b0);
        checkOutput("fips_t11_valid", 128'(o_key_valid), 128'd1);
        checkOutput("fips_t11_round", 128'(o_round),     128'd0);
        checkOutput("fips_t11_key",   o_round_key,       FIPS_CIPHER);
        applyStimulus(1'b0, 128'hdeadbeef, 1'b1, 1'b0);
        checkOutput("fips_t12_done",  128'(o_done),      128'd1);
        checkOutput("fips_t12_valid", 128'(o_key_valid), 128'd0);
        applyStimulus(1'b0, 128'hdeadbeef, 1'b1, 1'b0);
        checkOutput("fips_idle_busy", 128'(o_busy), 128'd0);

        // Backpressure at round 7.
        $display("[TB] backpressure");
        applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, FIPS_R10, 1'b0, 1'b0);
            checkOutput("stall_valid", 128'(o_key_valid), 128'd1);
            checkOutput("stall_round", 128'(o_round),     128'd7);
        end
        runToDone(40, 1'b0, nKeys, lastKey);
        checkOutput("stall_remaining_keys", 128'(nKeys), 128'd8);
        checkOutput("stall_round0_key",     lastKey,     FIPS_CIPHER);
        applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);

        // Start pulsed while busy is ignored.
        $display("[TB] start while busy");
        applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);
        checkOutput("busy_start_round", 128'(o_round), 128'd5);
        s         = expandKey(128'h000102030405060708090a0b0c0d0e0f);
        otherLast = s[10];
        tbCipher  = 128'h000102030405060708090a0b0c0d0e0f;
        applyStimulus(1'b1, otherLast, 1'b1, 1'b0);
        runToDone(40, 1'b0, nKeys, lastKey);
        checkOutput("busy_start_keys",   128'(nKeys), 128'd5);
        checkOutput("busy_start_round0", lastKey,     FIPS_CIPHER);
        tbCipher = FIPS_CIPHER;
        applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);

        // Reset in the middle of a schedule.
        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);
        checkOutput("midrst_round_before", 128'(o_round), 128'd4);
        applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b1);
        checkOutput("midrst_valid", 128'(o_key_valid), 128'd0);
        checkOutput("midrst_busy",  128'(o_busy),      128'd0);
        checkOutput("midrst_round", 128'(o_round),     128'd0);
        checkOutput("midrst_key",   o_round_key,       128'd0);
        applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b0);
        runToDone(40, 1'b0, nKeys, lastKey);
        checkOutput("postrst_keys",   128'(nKeys), 128'd11);
        checkOutput("postrst_round0", lastKey,     FIPS_CIPHER);
        applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);

        // Start held high: schedules run back to back with one idle gap.
        $display("[TB] back-to-back");
        doneCount = 0;
        doneAt[0] = 0;
        doneAt[1] = 0;
        for (int n = 1; n <= 26; n++) begin
            applyStimulus(1'b1, FIPS_R10, 1'b1, 1'b0);
            if (o_done) begin
                if (doneCount < 2) doneAt[doneCount] = n;
                doneCount++;
            end
        end
        checkOutput("b2b_done_count",  128'(doneCount), 128'd2);
        checkOutput("b2b_first_done",  128'(doneAt[0]), 128'd12);
        checkOutput("b2b_second_done", 128'(doneAt[1]), 128'd25);
        applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);
        applyStimulus(1'b0, FIPS_R10, 1'b1, 1'b0);

        // Random cipher keys with random backpressure.
        $display("[TB] random keys");
        for (int k = 0; k < 100; k++) begin
            tbCipher = {$urandom, $urandom, $urandom, $urandom};
            s        = expandKey(tbCipher);
            applyStimulus(1'b1, s[10], 1'b1, 1'b0);
            runToDone(200, 1'b1, nKeys, lastKey);
            checkOutput("rand_keys",   128'(nKeys), 128'd11);
            checkOutput("rand_round0", lastKey,     tbCipher);
            applyStimulus(1'b0, s[10], 1'b0, 1'b0);
        end

        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
